// File: rtl/cmp_pkg.sv
// Shared types for the comparator-based frame units.
// Data width and the frame-maximum FSM state encoding.
package cmp_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } mf_state_t;

endpackage

// File: rtl/arvore.sv
// 8-bit unsigned tree comparator.
// M = a > b, I = a == b, resolved by a log2 tree of bit pairs.
module arvore
  import cmp_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              M,
  output logic              I
);

  logic [7:0] w_g0, w_e0;
  logic [3:0] w_g1, w_e1;
  logic [1:0] w_g2, w_e2;

  assign w_g0 = a & ~b;
  assign w_e0 = ~(a ^ b);

  // Each node: the high half decides unless it is equal.
  for (genvar j = 0; j < 4; j++) begin : g_l1
    assign w_g1[j] = w_g0[2*j+1] | (w_e0[2*j+1] & w_g0[2*j]);
    assign w_e1[j] = w_e0[2*j+1] & w_e0[2*j];
  end

  for (genvar j = 0; j < 2; j++) begin : g_l2
    assign w_g2[j] = w_g1[2*j+1] | (w_e1[2*j+1] & w_g1[2*j]);
    assign w_e2[j] = w_e1[2*j+1] & w_e1[2*j];
  end

  assign M = w_g2[1] | (w_e2[1] & w_g2[0]);
  assign I = w_e2[1] & w_e2[0];

endmodule

// File: rtl/max_finder.sv
// Streaming frame-maximum unit: max value, first index, tie count.
// Handshake flags decode from the state register only.
module max_finder
  import cmp_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N),
  parameter int CW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] max_val,
  output logic [IW-1:0]     max_idx,
  output logic [CW-1:0]     tie_cnt,
  output logic              busy
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  mf_state_t         r_state;
  logic [IW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_max;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_tie;

  logic w_m;
  logic w_i;

  arvore u_cmp (
    .a (in_data),
    .b (r_max),
    .M (w_m),
    .I (w_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_max   <= '0;
      r_idx   <= '0;
      r_tie   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= COLLECT;
            r_cnt   <= '0;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            // First sample loads unconditionally, ignoring the compare.
            if (r_cnt == '0) begin
              r_max <= in_data;
              r_idx <= '0;
              r_tie <= CW'(1);
            end else if (w_m) begin
              r_max <= in_data;
              r_idx <= r_cnt;
              r_tie <= CW'(1);
            end else if (w_i) begin
              r_tie <= r_tie + CW'(1);
            end
            r_cnt <= r_cnt + IW'(1);
            if (r_cnt == LAST) r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign max_val   = r_max;
  assign max_idx   = r_idx;
  assign tie_cnt   = r_tie;

endmodule

// File: tb/tb_max_finder.sv
// Self-checking bench for max_finder (N=8).
// Expected results are queued per frame and popped at out_valid.
module tb_max_finder;

  localparam int N = 8;

  typedef logic [7:0] frame_t [N];

  typedef struct packed {
    logic [7:0] v;
    logic [2:0] i;
    logic [3:0] t;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] max_val;
  logic [2:0] max_idx;
  logic [3:0] tie_cnt;
  logic       busy;

  res_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  max_finder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .max_idx   (max_idx),
    .tie_cnt   (tie_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: find max, then first position, then count equal samples.
  function automatic res_t model(input frame_t d);
    res_t r;
    logic [7:0] m;
    int first;
    int cnt;
    m = d[0];
    for (int k = 1; k < N; k++) if (d[k] > m) m = d[k];
    first = -1;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      if (d[k] == m) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    r.v = m;
    r.i = first[2:0];
    r.t = cnt[3:0];
    return r;
  endfunction

  task automatic drive_frame(input frame_t d, input bit bubbles,
                             output int lat);
    sb.push_back(model(d));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_to_ready: in_ready=%b want 1", in_ready);
    end
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL early_valid: out_valid=%b want 0", out_valid);
        end
      end
      in_valid = 1'b1;
      in_data = d[k];
      @(posedge clk); #1 lat++;
      if (bubbles && k < N - 1) begin
        in_valid = 1'b0;
        in_data = 8'hEE;
        @(posedge clk); #1 lat++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, output res_t e);
    int w = 0;
    while (out_valid !== 1'b1 && w < 40) begin
      @(posedge clk); #1 w++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%b want 1", tag, out_valid);
    end
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    n_tests++;
    if (max_val !== e.v) begin
      n_fail++;
      $display("FAIL %s_max_val: got %0d want %0d", tag, max_val, e.v);
    end
    n_tests++;
    if (max_idx !== e.i) begin
      n_fail++;
      $display("FAIL %s_max_idx: got %0d want %0d", tag, max_idx, e.i);
    end
    n_tests++;
    if (tie_cnt !== e.t) begin
      n_fail++;
      $display("FAIL %s_tie_cnt: got %0d want %0d", tag, tie_cnt, e.t);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: busy=%b out_valid=%b want 0 0",
               tag, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({in_ready, out_valid, busy, max_val, max_idx, tie_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b ov=%b busy=%b mv=%0d mi=%0d tc=%0d want all 0",
               in_ready, out_valid, busy, max_val, max_idx, tie_cnt);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    frame_t d;
    res_t e;
    int lat;
    d = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd4, 8'd0, 8'd7, 8'd2};
    drive_frame(d, 1'b0, lat);
    n_tests++;
    if (out_valid !== 1'b1 || lat != N) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid=%b edges=%0d want 1 %0d",
               out_valid, lat, N);
    end
    check_result("basic", e);
    release_result("basic");
  endtask

  task automatic test_zeros();
    frame_t d;
    res_t e;
    int lat;
    // Samples offered in IDLE must not be consumed.
    in_valid = 1'b1;
    in_data = 8'hAA;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignore: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    d = '{default: 8'h00};
    drive_frame(d, 1'b0, lat);
    check_result("zeros", e);
    release_result("zeros");
  endtask

  task automatic test_bubbles();
    frame_t d;
    res_t e;
    int lat;
    for (int k = 0; k < N; k++) d[k] = 8'hFF - 8'(k);
    drive_frame(d, 1'b1, lat);
    n_tests++;
    if (out_valid !== 1'b1 || lat != N + 7) begin
      n_fail++;
      $display("FAIL bubble_latency: out_valid=%b edges=%0d want 1 %0d",
               out_valid, lat, N + 7);
    end
    check_result("bubbles", e);
    release_result("bubbles");
  endtask

  task automatic test_stall();
    frame_t d;
    res_t e;
    int lat;
    d = '{8'd50, 8'd60, 8'd60, 8'd10, 8'd60, 8'd20, 8'd5, 8'd59};
    drive_frame(d, 1'b0, lat);
    check_result("stall", e);
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      in_valid = 1'b1;
      in_data = 8'hFF;
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
          max_val !== e.v || max_idx !== e.i || tie_cnt !== e.t) begin
        n_fail++;
        $display("FAIL stall_hold%0d: ov=%b busy=%b rdy=%b mv=%0d mi=%0d tc=%0d want 1 1 0 %0d %0d %0d",
                 k, out_valid, busy, in_ready, max_val, max_idx, tie_cnt,
                 e.v, e.i, e.t);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: busy=%b ov=%b want 0 0", busy, out_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || max_val !== e.v || tie_cnt !== e.t) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b mv=%0d tc=%0d want 0 %0d %0d",
               busy, max_val, tie_cnt, e.v, e.t);
    end
  endtask

  task automatic test_reset_midframe();
    frame_t d;
    res_t e;
    int lat;
    logic [7:0] part [4];
    part = '{8'd10, 8'd20, 8'd30, 8'd40};
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data = part[k];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, busy, max_val, max_idx, tie_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: rdy=%b ov=%b busy=%b mv=%0d mi=%0d tc=%0d want all 0",
               in_ready, out_valid, busy, max_val, max_idx, tie_cnt);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    d = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd6};
    drive_frame(d, 1'b0, lat);
    check_result("post_reset", e);
    release_result("post_reset");
  endtask

  task automatic test_increasing();
    frame_t d;
    res_t e;
    for (int k = 0; k < N; k++) d[k] = 8'(k + 1);
    sb.push_back(model(d));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data = d[k];
      @(posedge clk); #1;
      n_tests++;
      if (max_idx !== 3'(k) || max_val !== d[k]) begin
        n_fail++;
        $display("FAIL inc_track%0d: mi=%0d mv=%0d want %0d %0d",
                 k, max_idx, max_val, k, d[k]);
      end
    end
    in_valid = 1'b0;
    check_result("increasing", e);
    release_result("increasing");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zeros();
    test_bubbles();
    test_stall();
    test_reset_midframe();
    test_increasing();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
